// File: rtl/uart_alici_ornekleyici.sv
// Mid-bit sampling 8N1 UART receiver with a single-entry valid/ready output register.
// Start, data and stop bits are each sampled once, half a bit period after the start edge plus whole bit periods.
module uart_alici_ornekleyici #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_en_i,
    input  logic [15:0]          baud_div_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] veri_o,
    output logic                 veri_gecerli_o,
    input  logic                 veri_hazir_i,
    output logic                 cerceve_hatasi_o,
    output logic                 tasma_o,
    output logic                 mesgul_o
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] BASLA = 2'd1;
    localparam logic [1:0] VERI  = 2'd2;
    localparam logic [1:0] DUR   = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [1:0]             state_q;
    logic [15:0]            div_q;
    logic [15:0]            cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_BITS-1:0]   shift_q;

    logic [15:0]            baud_eff;
    logic                   sample_tick;
    logic                   stop_sample;
    logic                   deliver;
    logic                   frame_err;
    logic                   take;

    // Synchroniser presets to the idle (high) level so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s        = sync_q[SYNC_STAGES-1];
    assign baud_eff    = (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
    assign sample_tick = (cnt_q == 16'd0);
    assign stop_sample = (state_q == DUR) && rx_en_i && sample_tick;
    assign deliver     = stop_sample && rx_s;
    assign frame_err   = stop_sample && !rx_s;
    assign take        = veri_gecerli_o && veri_hazir_i;
    assign mesgul_o    = (state_q != BOSTA);

    // Frame sequencer; dropping the enable abandons any partial frame silently.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= BOSTA;
            div_q   <= 16'd4;
            cnt_q   <= 16'd0;
            idx_q   <= '0;
            shift_q <= '0;
        end else if ((state_q != BOSTA) && !rx_en_i) begin
            state_q <= BOSTA;
        end else begin
            case (state_q)
                BOSTA: begin
                    if (rx_en_i && !rx_s) begin
                        state_q <= BASLA;
                        div_q   <= baud_eff;
                        cnt_q   <= (baud_eff >> 1) - 16'd1;
                    end
                end
                BASLA: begin
                    if (sample_tick) begin
                        if (!rx_s) begin
                            state_q <= VERI;
                            cnt_q   <= div_q - 16'd1;
                            idx_q   <= '0;
                        end else begin
                            state_q <= BOSTA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                VERI: begin
                    if (sample_tick) begin
                        shift_q[idx_q] <= rx_s;
                        cnt_q          <= div_q - 16'd1;
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_q <= DUR;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DUR: begin
                    if (sample_tick) begin
                        state_q <= BOSTA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= BOSTA;
                end
            endcase
        end
    end

    // A byte lands only if the register is empty or being drained this very cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            veri_o           <= '0;
            veri_gecerli_o   <= 1'b0;
            cerceve_hatasi_o <= 1'b0;
            tasma_o          <= 1'b0;
        end else begin
            cerceve_hatasi_o <= frame_err;
            tasma_o          <= 1'b0;
            if (deliver) begin
                if (!veri_gecerli_o || take) begin
                    veri_o         <= shift_q;
                    veri_gecerli_o <= 1'b1;
                end else begin
                    tasma_o <= 1'b1;
                end
            end else if (take) begin
                veri_gecerli_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_alici_ornekleyici.sv
// Scoreboard bench for uart_alici_ornekleyici: a frame-level model predicts delivery/overrun/framing
// events at stimulus time, and an independent monitor pops and compares them as the DUT reports them.
module tb_uart_alici_ornekleyici;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx = 1'b1;
    logic        hazir = 1'b0;
    logic [15:0] baud_div = 16'd16;
    logic [7:0]  veri;
    logic        gecerli;
    logic        fe;
    logic        ovr;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Event kinds: 0 = byte delivered, 1 = framing error, 2 = overrun.
    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    bit         model_full = 1'b0;
    logic [7:0] held = 8'h00;
    bit         prev_valid = 1'b0;
    bit         prev_take = 1'b0;

    uart_alici_ornekleyici #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .rx_en_i          (rx_en),
        .baud_div_i       (baud_div),
        .rx_i             (rx),
        .veri_o           (veri),
        .veri_gecerli_o   (gecerli),
        .veri_hazir_i     (hazir),
        .cerceve_hatasi_o (fe),
        .tasma_o          (ovr),
        .mesgul_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int d_eff(input logic [15:0] d);
        return (d < 16'd4) ? 4 : int'(d);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level prediction: only the stop bit, the register occupancy and the consumer's readiness matter.
    task automatic modelFrame(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        e.data = b;
        if (!stop_ok) begin
            e.kind = 1;
        end else if (model_full && !hazir) begin
            e.kind = 2;
        end else begin
            e.kind = 0;
            model_full = !hazir;
        end
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input logic [15:0] d,
                                 input bit expect_out, input int abort_at);
        int p;
        p = d_eff(d);
        baud_div = d;
        if (expect_out) modelFrame(b, stop_ok);
        rx = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) rx_en = 1'b0;
            rx = b[i];
            tick(p);
        end
        rx = stop_ok;
        tick(p);
        rx = 1'b1;
    endtask

    task automatic consume();
        hazir = 1'b1;
        model_full = 1'b0;
        tick(1);
        hazir = 1'b0;
        checkOutput("valid_clears_after_accept", gecerli, 1'b0);
    endtask

    task automatic popCheck(input int kind, input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: got unexpected event kind %0d, expected no event at %0t", name, kind, $time);
        end else begin
            e = sb_q.pop_front();
            checkOutput(name, kind, e.kind);
            if (kind == 0 && e.kind == 0) begin
                checkOutput("delivered_byte", veri, e.data);
                held = e.data;
            end
        end
    endtask

    task automatic measureLatency(input int d);
        int  c;
        bit  ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
        c = 0;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            c++;
            if (gecerli) ok = 1'b1;
        end
        checkOutput("single_byte_latency", c, d / 2 + 9 * d);
    endtask

    // Monitor: sampled on the falling edge, well away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_valid = 1'b0;
            prev_take  = 1'b0;
            held       = 8'h00;
        end else begin
            if (gecerli && !(prev_valid && !prev_take)) begin
                popCheck(0, "event_delivery");
            end else if (gecerli) begin
                checkOutput("held_byte_stable", veri, held);
            end
            if (fe) popCheck(1, "event_framing_error");
            if (ovr) begin
                popCheck(2, "event_overrun");
                checkOutput("overrun_keeps_old_byte", veri, held);
            end
            prev_valid = gecerli;
            prev_take  = gecerli && hazir;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  rb;
        logic [15:0] rd;
        bit          rstop;

        tick(3);
        checkOutput("reset_veri", veri, 8'h00);
        checkOutput("reset_gecerli", gecerli, 1'b0);
        checkOutput("reset_cerceve", fe, 1'b0);
        checkOutput("reset_tasma", ovr, 1'b0);
        checkOutput("reset_mesgul", busy, 1'b0);
        rstn = 1'b1;
        rx_en = 1'b1;
        tick(5);

        $display("[TB] single byte");
        hazir = 1'b0;
        fork
            applyStimulus(8'hA5, 1'b1, 16'd16, 1'b1, -1);
            measureLatency(16);
        join
        tick(20);
        checkOutput("single_valid_held", gecerli, 1'b1);
        checkOutput("single_data_held", veri, 8'hA5);
        consume();
        tick(10);

        $display("[TB] glitch rejection");
        baud_div = 16'd16;
        fork
            begin
                rx = 1'b0;
                tick(3);
                rx = 1'b1;
            end
            begin
                int c;
                c = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (busy) c++;
                end
                checkOutput("glitch_busy_cycles", c, 8);
            end
        join
        tick(2);
        checkOutput("glitch_idle", busy, 1'b0);

        $display("[TB] framing error");
        applyStimulus(8'h3C, 1'b0, 16'd16, 1'b1, -1);
        tick(30);
        checkOutput("framing_no_valid", gecerli, 1'b0);
        checkOutput("framing_drained", sb_q.size(), 0);

        $display("[TB] overrun");
        applyStimulus(8'h3C, 1'b1, 16'd16, 1'b1, -1);
        applyStimulus(8'h7E, 1'b1, 16'd16, 1'b1, -1);
        tick(30);
        checkOutput("overrun_valid", gecerli, 1'b1);
        checkOutput("overrun_data", veri, 8'h3C);
        checkOutput("overrun_drained", sb_q.size(), 0);
        consume();

        $display("[TB] streaming");
        hazir = 1'b1;
        model_full = 1'b0;
        tick(1);
        applyStimulus(8'h00, 1'b1, 16'd4, 1'b1, -1);
        applyStimulus(8'hFF, 1'b1, 16'd4, 1'b1, -1);
        applyStimulus(8'h55, 1'b1, 16'd4, 1'b1, -1);
        tick(20);
        hazir = 1'b0;
        checkOutput("streaming_drained", sb_q.size(), 0);

        $display("[TB] enable abort");
        fork
            applyStimulus(8'hC3, 1'b1, 16'd16, 1'b0, 4);
            begin
                wait (rx_en == 1'b0);
                tick(1);
                checkOutput("abort_en_idle", busy, 1'b0);
            end
        join
        tick(20);
        rx_en = 1'b1;
        tick(5);
        checkOutput("abort_en_no_valid", gecerli, 1'b0);

        $display("[TB] reset abort");
        applyStimulus(8'h96, 1'b1, 16'd16, 1'b1, -1);
        tick(30);
        checkOutput("held_before_reset", gecerli, 1'b1);
        fork
            applyStimulus(8'h5A, 1'b1, 16'd16, 1'b0, -1);
            begin
                tick(60);
                rstn = 1'b0;
                #1;
                checkOutput("rst_mid_veri", veri, 8'h00);
                checkOutput("rst_mid_gecerli", gecerli, 1'b0);
                checkOutput("rst_mid_cerceve", fe, 1'b0);
                checkOutput("rst_mid_tasma", ovr, 1'b0);
                checkOutput("rst_mid_mesgul", busy, 1'b0);
                sb_q.delete();
                model_full = 1'b0;
            end
        join
        tick(5);
        rstn = 1'b1;
        tick(5);
        applyStimulus(8'h81, 1'b1, 16'd16, 1'b1, -1);
        tick(30);
        checkOutput("after_reset_valid", gecerli, 1'b1);
        checkOutput("after_reset_data", veri, 8'h81);
        consume();

        $display("[TB] randomized frames");
        for (int k = 0; k < 14; k++) begin
            rd = 16'($urandom_range(0, 20));
            rb = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            hazir = 1'($urandom_range(0, 1));
            if (hazir) model_full = 1'b0;
            tick(1);
            applyStimulus(rb, rstop, rd, 1'b1, -1);
            tick(d_eff(rd) + 6);
            if (!hazir && ($urandom_range(0, 1) == 1)) consume();
        end
        hazir = 1'b0;
        tick(50);
        checkOutput("final_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
